// File: rtl/dac_spi_tx.sv
// Serialises 9-bit sine samples into 16-bit {CMD, sample, 000} SPI frames for an external DAC.
// Frame cadence: accept, SETUP, 16 sclk periods, chip-select gap, then back to IDLE.
module dac_spi_tx #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_GAP  = 2,
    parameter logic [3:0]  CMD     = 4'b0011
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] sample_in,
    input  logic       sample_valid,
    output logic       sample_ready,
    output logic       dac_cs_n,
    output logic       dac_sclk,
    output logic       dac_mosi,
    output logic       busy,
    output logic [7:0] overrun_cnt
);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_e;

    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LOAD = 8'(CS_GAP - 1);

    state_e      state_q;
    logic [15:0] frame_q;
    logic [15:0] frame_d;
    logic [7:0]  div_q;
    logic [4:0]  half_q;
    logic [7:0]  overrun_q;
    logic [7:0]  overrun_d;
    logic        ready_q;
    logic        cs_n_q;
    logic        sclk_q;
    logic        mosi_q;
    logic        busy_q;

    always_comb begin
        frame_d   = {CMD, sample_in, 3'b000};
        overrun_d = overrun_q;
        if (sample_valid && !ready_q && overrun_q != 8'hFF) begin
            overrun_d = overrun_q + 8'd1;
        end
    end

    // NOTE: every register here updates with <= so all branches see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            div_q     <= '0;
            half_q    <= '0;
            overrun_q <= '0;
            ready_q   <= 1'b0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
            unique case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (sample_valid && ready_q) begin
                        frame_q <= frame_d;
                        mosi_q  <= frame_d[15];
                        cs_n_q  <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        div_q   <= DIV_LOAD;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_q == 8'd0) begin
                        div_q   <= DIV_LOAD;
                        half_q  <= 5'd0;
                        state_q <= SHIFT;
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end
                SHIFT: begin
                    if (div_q == 8'd0) begin
                        div_q  <= DIV_LOAD;
                        half_q <= half_q + 5'd1;
                        sclk_q <= ~sclk_q;
                        // Falling edge: advance data, or close the frame after the 32nd half-period.
                        if (sclk_q) begin
                            if (half_q == 5'd31) begin
                                cs_n_q  <= 1'b1;
                                mosi_q  <= 1'b0;
                                div_q   <= GAP_LOAD;
                                state_q <= GAP;
                            end else begin
                                mosi_q  <= frame_q[14];
                                frame_q <= {frame_q[14:0], 1'b0};
                            end
                        end
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end
                GAP: begin
                    if (div_q == 8'd0) begin
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        div_q <= div_q - 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sample_ready = ready_q;
    assign dac_cs_n     = cs_n_q;
    assign dac_sclk     = sclk_q;
    assign dac_mosi     = mosi_q;
    assign busy         = busy_q;
    assign overrun_cnt  = overrun_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Scoreboarded bench: stimulus queues expected frames, a serial monitor decodes the SPI lines and compares.
// Instance 0 runs default parameters, instance 1 runs CLK_DIV=1, CS_GAP=1.
module tb_dac_spi_tx;

    localparam int DIV0 = 2;
    localparam int GAP0 = 2;
    localparam int DIV1 = 1;
    localparam int GAP1 = 1;
    // Accept-to-accept period is 1 + CLK_DIV + 32*CLK_DIV + CS_GAP cycles.
    localparam int PER0 = 1 + DIV0 + 32 * DIV0 + GAP0;
    localparam int PER1 = 1 + DIV1 + 32 * DIV1 + GAP1;

    logic       clk = 1'b0;
    logic       rst  [2];
    logic [8:0] smp  [2];
    logic       vld  [2];
    logic       rdy  [2];
    logic       cs_n [2];
    logic       sclk [2];
    logic       mosi [2];
    logic       busy [2];
    logic [7:0] ovr  [2];

    always #5 clk = ~clk;

    dac_spi_tx #(.CLK_DIV(DIV0), .CS_GAP(GAP0), .CMD(4'b0011)) dut0 (
        .clk(clk), .rst(rst[0]), .sample_in(smp[0]), .sample_valid(vld[0]),
        .sample_ready(rdy[0]), .dac_cs_n(cs_n[0]), .dac_sclk(sclk[0]),
        .dac_mosi(mosi[0]), .busy(busy[0]), .overrun_cnt(ovr[0])
    );

    dac_spi_tx #(.CLK_DIV(DIV1), .CS_GAP(GAP1), .CMD(4'b0011)) dut1 (
        .clk(clk), .rst(rst[1]), .sample_in(smp[1]), .sample_valid(vld[1]),
        .sample_ready(rdy[1]), .dac_cs_n(cs_n[1]), .dac_sclk(sclk[1]),
        .dac_mosi(mosi[1]), .busy(busy[1]), .overrun_cnt(ovr[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q0 [$];
    logic [15:0] exp_q1 [$];
    int          acc_q0 [$];
    int          acc_q1 [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int i, input logic [15:0] f);
        if (i == 0) exp_q0.push_back(f);
        else        exp_q1.push_back(f);
    endtask

    task automatic pop_exp(input int i, output logic [15:0] f, output bit ok);
        ok = 1'b0;
        f  = '0;
        if (i == 0 && exp_q0.size() > 0) begin f = exp_q0.pop_front(); ok = 1'b1; end
        if (i == 1 && exp_q1.size() > 0) begin f = exp_q1.pop_front(); ok = 1'b1; end
    endtask

    // ---------------- monitor ----------------
    bit          in_fr      [2] = '{0, 0};
    logic        prev_cs    [2] = '{1'b1, 1'b1};
    logic        prev_sclk  [2] = '{1'b0, 1'b0};
    logic        prev_mosi  [2] = '{1'b0, 1'b0};
    int          nbits      [2];
    int          low_cnt    [2];
    int          fall_cyc   [2];
    int          last_rise  [2];
    bit          bad_timing [2];
    bit          glitch     [2];
    logic [15:0] shreg      [2];
    int          ncyc = 0;

    always @(negedge clk) begin
        ncyc++;
        for (int i = 0; i < 2; i++) begin
            int          dv;
            logic [15:0] ef;
            bit          ok;
            dv = (i == 0) ? DIV0 : DIV1;
            if (rst[i]) begin
                if (in_fr[i]) begin
                    pop_exp(i, ef, ok);
                    in_fr[i] = 1'b0;
                end
                prev_cs[i]   = 1'b1;
                prev_sclk[i] = 1'b0;
                prev_mosi[i] = 1'b0;
            end else begin
                if (prev_cs[i] && !cs_n[i]) begin
                    in_fr[i]      = 1'b1;
                    nbits[i]      = 0;
                    low_cnt[i]    = 1;
                    fall_cyc[i]   = ncyc;
                    last_rise[i]  = ncyc;
                    bad_timing[i] = 1'b0;
                    glitch[i]     = 1'b0;
                    shreg[i]      = '0;
                    if (i == 0) acc_q0.push_back(ncyc);
                    else        acc_q1.push_back(ncyc);
                end else if (in_fr[i] && !cs_n[i]) begin
                    low_cnt[i]++;
                    if (!prev_sclk[i] && sclk[i]) begin
                        nbits[i]++;
                        shreg[i] = {shreg[i][14:0], mosi[i]};
                        if (ncyc - last_rise[i] != 2 * dv) bad_timing[i] = 1'b1;
                        last_rise[i] = ncyc;
                    end
                    if (mosi[i] !== prev_mosi[i] && !(prev_sclk[i] && !sclk[i])) glitch[i] = 1'b1;
                end else if (in_fr[i] && cs_n[i]) begin
                    in_fr[i] = 1'b0;
                    pop_exp(i, ef, ok);
                    if (!ok) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_frame[%0d]: got 0x%0h, expected none", i, shreg[i]);
                    end else begin
                        check($sformatf("frame[%0d]", i), shreg[i], ef);
                        check($sformatf("rise_count[%0d]", i), nbits[i], 16);
                        check($sformatf("cs_low_cycles[%0d]", i), low_cnt[i], 33 * dv);
                        check($sformatf("sclk_timing[%0d]", i), bad_timing[i], 0);
                        check($sformatf("mosi_stable[%0d]", i), glitch[i], 0);
                        check($sformatf("sclk_low_at_cs_rise[%0d]", i), sclk[i], 0);
                    end
                end
                prev_cs[i]   = cs_n[i];
                prev_sclk[i] = sclk[i];
                prev_mosi[i] = mosi[i];
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input int i);
        int t = 0;
        while (!rdy[i] && t < 500) begin
            step();
            t++;
        end
        check($sformatf("wait_ready[%0d]", i), rdy[i], 1'b1);
    endtask

    task automatic send(input int i, input logic [8:0] s, input logic [15:0] f);
        wait_ready(i);
        smp[i] = s;
        vld[i] = 1'b1;
        push_exp(i, f);
        step();
        vld[i] = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n;
        int bc;
        int r;
        int guard;
        logic prev;
        logic [15:0] tbl032 [3];
        tbl032[0] = 16'h3000;
        tbl032[1] = 16'h3008;
        tbl032[2] = 16'h3010;

        rst[0] = 1'b1; rst[1] = 1'b1;
        vld[0] = 1'b0; vld[1] = 1'b0;
        smp[0] = '0;   smp[1] = '0;
        step();
        check("rst_cs_n", cs_n[0], 1'b1);
        check("rst_sclk", sclk[0], 1'b0);
        check("rst_mosi", mosi[0], 1'b0);
        check("rst_ready", rdy[0], 1'b0);
        check("rst_busy", busy[0], 1'b0);
        check("rst_overrun", ovr[0], 8'd0);
        rst[0] = 1'b0; rst[1] = 1'b0;
        step();
        check("ready_after_first_edge", rdy[0], 1'b1);

        // Single 9'h1FF frame; valid held 10 extra busy cycles.
        wait_ready(0);
        smp[0] = 9'h1FF;
        vld[0] = 1'b1;
        push_exp(0, 16'h3FF8);
        step();
        check("accept_cs_n", cs_n[0], 1'b0);
        check("accept_busy", busy[0], 1'b1);
        check("accept_ready", rdy[0], 1'b0);
        check("accept_mosi_msb", mosi[0], 1'b0);
        repeat (10) step();
        vld[0] = 1'b0;
        check("overrun_10", ovr[0], 8'd10);
        wait_ready(0);

        // sample_in toggled every cycle after accept.
        wait_ready(0);
        smp[0] = 9'h155;
        vld[0] = 1'b1;
        push_exp(0, 16'h3AA8);
        step();
        vld[0] = 1'b0;
        for (int k = 0; k < 80; k++) begin
            smp[0] = (k % 2 == 0) ? 9'h0AA : 9'h155;
            step();
        end
        wait_ready(0);

        // Back-to-back accepts 0,1,2 with valid held high.
        acc_q0.delete();
        vld[0] = 1'b1;
        n = 0;
        guard = 0;
        while (n < 3 && guard < 1000) begin
            if (rdy[0]) begin
                smp[0] = 9'(n);
                push_exp(0, tbl032[n]);
                n++;
            end
            step();
            guard++;
        end
        vld[0] = 1'b0;
        wait_ready(0);
        check("accept_count_032", acc_q0.size(), 3);
        if (acc_q0.size() == 3) begin
            check("accept_spacing_1", acc_q0[1] - acc_q0[0], PER0);
            check("accept_spacing_2", acc_q0[2] - acc_q0[1], PER0);
        end

        // Overrun saturation over 400 busy cycles with valid high.
        smp[0] = 9'h0F0;
        vld[0] = 1'b1;
        bc = 0;
        while (bc < 300) begin
            if (rdy[0]) push_exp(0, 16'h3780);
            else        bc++;
            step();
        end
        check("overrun_sat_300", ovr[0], 8'd255);
        while (bc < 400) begin
            if (rdy[0]) push_exp(0, 16'h3780);
            else        bc++;
            step();
        end
        vld[0] = 1'b0;
        check("overrun_sat_400", ovr[0], 8'd255);
        wait_ready(0);

        // Reset after the 5th rising sclk edge.
        send(0, 9'h100, 16'h3800);
        r = 0;
        guard = 0;
        prev = sclk[0];
        while (r < 5 && guard < 200) begin
            step();
            if (sclk[0] && !prev) r++;
            prev = sclk[0];
            guard++;
        end
        check("five_rises_seen", r, 5);
        rst[0] = 1'b1;
        #1;
        check("abort_cs_n", cs_n[0], 1'b1);
        check("abort_sclk", sclk[0], 1'b0);
        check("abort_mosi", mosi[0], 1'b0);
        check("abort_busy", busy[0], 1'b0);
        check("abort_overrun_clr", ovr[0], 8'd0);
        step();
        step();
        rst[0] = 1'b0;
        check("ready_low_at_release", rdy[0], 1'b0);
        step();
        check("ready_after_release", rdy[0], 1'b1);
        send(0, 9'h1FF, 16'h3FF8);
        wait_ready(0);
        check("no_overrun_after_reset", ovr[0], 8'd0);

        // CLK_DIV=1, CS_GAP=1 instance: two accepts of 9'h0AA.
        acc_q1.delete();
        smp[1] = 9'h0AA;
        vld[1] = 1'b1;
        n = 0;
        guard = 0;
        while (n < 2 && guard < 500) begin
            if (rdy[1]) begin
                push_exp(1, 16'h3550);
                n++;
            end
            step();
            guard++;
        end
        vld[1] = 1'b0;
        wait_ready(1);
        check("accept_count_035", acc_q1.size(), 2);
        if (acc_q1.size() == 2) check("accept_spacing_div1", acc_q1[1] - acc_q1[0], PER1);

        repeat (5) step();
        check("exp_q0_drained", exp_q0.size(), 0);
        check("exp_q1_drained", exp_q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
